// File: rtl/biu_port_if.sv
// EU <-> BIU handshake and load-port bundle. The data bus itself stays a plain
// inout on biu_port; bus_oe exposes when the BIU is driving it.
interface biu_port_if #(parameter int ADDR_W = 4);
  logic              cs_biu;
  logic [1:0]        sel;
  logic [1:0]        op_sel;
  logic [ADDR_W-1:0] addr_a;
  logic [ADDR_W-1:0] addr_b;
  logic              ready_biu;
  logic              err;
  logic              bus_oe;
  logic              ld_en;
  logic [ADDR_W-1:0] ld_addr;
  logic [15:0]       ld_data;

  modport master (
    output cs_biu, sel, op_sel, addr_a, addr_b, ld_en, ld_addr, ld_data,
    input  ready_biu, err, bus_oe
  );

  modport slave (
    input  cs_biu, sel, op_sel, addr_a, addr_b, ld_en, ld_addr, ld_data,
    output ready_biu, err, bus_oe
  );
endinterface

// File: rtl/biu_port.sv
// BIU target: serves EU reads/writes over the shared tri-state bus from a local
// word memory. Define BIU_WAIT_EN to make WAIT last WAIT_CYCLES (min 1) cycles.
module biu_port #(
  parameter int ADDR_W      = 4,
  parameter int WAIT_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  biu_port_if.slave  eu,
  inout  wire [15:0] bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_e;

  state_e            state_q;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q;
  logic              ready_q, err_q;
  logic [15:0]       mem_q [DEPTH];

  logic req, same_op, wait_last, rd_en;
  logic [ADDR_W-1:0] rd_addr;

  assign req     = eu.cs_biu && (eu.sel == 2'b10);
  assign same_op = (eu.op_sel == op_q);

`ifdef BIU_WAIT_EN
  localparam logic [3:0] WAIT_LAST = 4'((WAIT_CYCLES > 1) ? WAIT_CYCLES - 1 : 0);
  logic [3:0] cnt_q;
  assign wait_last = (cnt_q == WAIT_LAST);
`else
  // Fixed single-cycle WAIT; WAIT_CYCLES has no effect in this build.
  localparam bit WAIT_ONE = (WAIT_CYCLES >= 0) || 1'b1;
  assign wait_last = WAIT_ONE;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= 2'b00;
      addr_a_q <= '0;
      addr_b_q <= '0;
      ready_q  <= 1'b1;
      err_q    <= 1'b0;
`ifdef BIU_WAIT_EN
      cnt_q    <= 4'd0;
`endif
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req && eu.op_sel == 2'b11) begin
            err_q <= 1'b1;
          end else if (req) begin
            op_q     <= eu.op_sel;
            addr_a_q <= eu.addr_a;
            addr_b_q <= eu.addr_b;
            ready_q  <= 1'b0;
            state_q  <= S_WAIT;
`ifdef BIU_WAIT_EN
            cnt_q    <= 4'd0;
`endif
          end else if (eu.ld_en) begin
            // Load port only lands when no EU access was accepted this edge.
            mem_q[eu.ld_addr] <= eu.ld_data;
          end
        end
        S_WAIT: begin
`ifdef BIU_WAIT_EN
          cnt_q <= cnt_q + 4'd1;
`endif
          if (wait_last) begin
            ready_q <= 1'b1;
            state_q <= S_DONE;
            if (op_q == 2'b10) mem_q[addr_a_q] <= bus;
          end
        end
        S_DONE: begin
          if (!eu.cs_biu || !same_op) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Drive enable is combinational so the bus frees the instant the EU backs off.
  assign rd_en   = (state_q == S_DONE) && eu.cs_biu && same_op && !op_q[1];
  assign rd_addr = op_q[0] ? addr_b_q : addr_a_q;
  assign bus     = rd_en ? mem_q[rd_addr] : 16'hzzzz;

  assign eu.ready_biu = ready_q;
  assign eu.err       = err_q;
  assign eu.bus_oe    = rd_en;
endmodule

// File: tb/tb_biu_port.sv
// Directed bench for biu_port: transaction tasks keep a memory/expectation model,
// a negedge process compares the DUT against it every cycle.
module tb_biu_port;
  localparam int AW = 4;
  localparam int WC = 2;
`ifdef BIU_WAIT_EN
  localparam int WL = (WC > 1) ? WC : 1;
`else
  localparam int WL = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  biu_port_if #(.ADDR_W(AW)) bif();
  wire  [15:0] bus;
  logic        tb_drv = 1'b0;
  logic [15:0] tb_data = 16'h0000;
  assign bus = tb_drv ? tb_data : 16'hzzzz;

  biu_port #(.ADDR_W(AW), .WAIT_CYCLES(WC)) dut (
    .clk(clk), .rst_n(rst_n), .eu(bif.slave), .bus(bus)
  );

  logic [15:0] mem_m [16];
  logic        exp_ready = 1'b1, exp_err = 1'b0, exp_oe = 1'b0;
  logic [15:0] exp_data = 16'h0000;
  logic [15:0] rd_val;
  bit          chk_en = 1'b0;
  int          n_cmp = 0, n_bad = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("ready_biu", {15'd0, bif.ready_biu}, {15'd0, exp_ready});
      check("err",       {15'd0, bif.err},       {15'd0, exp_err});
      check("bus_oe",    {15'd0, bif.bus_oe},    {15'd0, exp_oe});
      if (exp_oe) check("bus_data", bus, exp_data);
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic load(input int a, input logic [15:0] d);
    bif.ld_en = 1'b1; bif.ld_addr = a[AW-1:0]; bif.ld_data = d;
    step();
    bif.ld_en = 1'b0;
    mem_m[a] = d;
  endtask

  // chained: entered from DONE with only op_sel changed, so one IDLE cycle first
  task automatic rd(input logic [1:0] op, input int a, input int b, input bit drop, input bit chained);
    bif.cs_biu = 1'b1; bif.sel = 2'b10; bif.op_sel = op;
    bif.addr_a = a[AW-1:0]; bif.addr_b = b[AW-1:0];
    exp_oe = 1'b0; exp_ready = 1'b1;
    if (chained) step();
    step();
    exp_ready = 1'b0;
    bif.ld_en = 1'b0;
    repeat (WL - 1) step();
    step();
    exp_ready = 1'b1; exp_oe = 1'b1; exp_data = mem_m[op[0] ? b : a];
    @(negedge clk); rd_val = bus;
    step();
    if (drop) begin
      bif.cs_biu = 1'b0; exp_oe = 1'b0;
      step();
    end
  endtask

  task automatic wr(input int a, input logic [15:0] d);
    bif.cs_biu = 1'b1; bif.sel = 2'b10; bif.op_sel = 2'b10; bif.addr_a = a[AW-1:0];
    tb_drv = 1'b1; tb_data = d; exp_oe = 1'b0;
    step();
    exp_ready = 1'b0;
    repeat (WL - 1) step();
    step();
    exp_ready = 1'b1; mem_m[a] = d;
    step();
    bif.cs_biu = 1'b0; tb_drv = 1'b0;
    step();
  endtask

  initial begin
    bif.cs_biu = 1'b0; bif.sel = 2'b00; bif.op_sel = 2'b00;
    bif.addr_a = '0; bif.addr_b = '0;
    bif.ld_en = 1'b0; bif.ld_addr = '0; bif.ld_data = 16'h0000;
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
    chk_en = 1'b1;
    step(); step();
    check("rst_ready_lit", {15'd0, bif.ready_biu}, 16'h0001);
    rst_n = 1'b1;
    step();

    // Load + read A, read B
    load(3, 16'h1234);
    load(5, 16'h00FF);
    rd(2'b00, 3, 0, 1'b1, 1'b0);
    check("rd_a3_lit", rd_val, 16'h1234);
    rd(2'b01, 0, 5, 1'b1, 1'b0);
    check("rd_b5_lit", rd_val, 16'h00FF);

    // Write then read back
    wr(7, 16'hBEEF);
    check("model_mem7_lit", mem_m[7], 16'hBEEF);
    rd(2'b00, 7, 0, 1'b1, 1'b0);
    check("rd_a7_lit", rd_val, 16'hBEEF);

    // Reserved op: err pulse only
    bif.cs_biu = 1'b1; bif.sel = 2'b10; bif.op_sel = 2'b11; bif.addr_a = 4'd7;
    step();
    exp_err = 1'b1; bif.cs_biu = 1'b0;
    step();
    exp_err = 1'b0;
    step();
    rd(2'b00, 7, 0, 1'b1, 1'b0);
    check("rsv_mem7_lit", rd_val, 16'hBEEF);

    // Unit not selected: request ignored
    bif.cs_biu = 1'b1; bif.sel = 2'b01; bif.op_sel = 2'b00;
    step(); step();
    bif.cs_biu = 1'b0; bif.sel = 2'b00;
    step();

    // Loads during DONE and on an accepting edge are dropped
    rd(2'b00, 3, 0, 1'b0, 1'b0);
    bif.ld_en = 1'b1; bif.ld_addr = 4'd2; bif.ld_data = 16'hDEAD;
    step();
    bif.ld_en = 1'b0; bif.cs_biu = 1'b0; exp_oe = 1'b0;
    step();
    bif.ld_en = 1'b1; bif.ld_addr = 4'd2; bif.ld_data = 16'hCAFE;
    rd(2'b00, 2, 0, 1'b1, 1'b0);
    check("ld_drop_lit", rd_val, 16'h0000);

    // Reset in the middle of WAIT
    bif.cs_biu = 1'b1; bif.sel = 2'b10; bif.op_sel = 2'b00; bif.addr_a = 4'd3;
    step();
    exp_ready = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0; bif.cs_biu = 1'b0;
    exp_ready = 1'b1; exp_oe = 1'b0;
    for (int i = 0; i < 16; i++) mem_m[i] = 16'h0000;
    #1 check("rst_async_ready_lit", {15'd0, bif.ready_biu}, 16'h0001);
    step(); step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 16; i++) rd(2'b00, i, 0, 1'b1, 1'b0);
    rd(2'b01, 0, 3, 1'b1, 1'b0);
    check("post_rst_mem3_lit", rd_val, 16'h0000);

    // EU-style: read A then read B by only changing op_sel
    load(9, 16'hA5A5);
    load(4, 16'h5A5A);
    rd(2'b00, 9, 4, 1'b0, 1'b0);
    check("eu_rd_a9_lit", rd_val, 16'hA5A5);
    rd(2'b01, 9, 4, 1'b1, 1'b1);
    check("eu_rd_b4_lit", rd_val, 16'h5A5A);
    step();

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/biu_port.md
# biu_port

Bus interface responder for the EU/ALU datapath: it serves EU operand-fetch and result-writeback requests over the shared 16-bit tri-state `bus`, backed by a small local word memory. The EU acts as initiator through `cs_biu`, `sel`, and `op_sel`. This block is the target: it inserts wait states, drives read data, captures write data, and reports completion on `ready_biu`. A side load port preloads memory for bring-up and test.

## Interface
- `ADDR_W`, default 4: memory address width; depth = 2**ADDR_W 16-bit words.
- `WAIT_CYCLES`, default 2: wait states per access (0..15), used only when `BIU_WAIT_EN` is defined.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `cs_biu` input 1: EU request strobe.
- `sel` input 2: unit select; only `2'b10` addresses this block.
- `op_sel` input 2: `00` read A, `01` read B, `10` write result to A, `11` reserved.
- `addr_a` input ADDR_W: operand-A / destination address.
- `addr_b` input ADDR_W: operand-B address.
- `bus` inout 16: shared data bus. This block drives it only during read completion; otherwise high-Z.
- `ready_biu` output 1: 1 = idle or access complete; 0 = access in progress.
- `err` output 1: one-cycle pulse on a reserved `op_sel`.
- `ld_en` input 1: load-port write enable.
- `ld_addr` input ADDR_W: load-port address.
- `ld_data` input 16: load-port data.

## Operation
- States: IDLE, WAIT, DONE.
- **IDLE**
  - `ready_biu`=1.
  - Request = `cs_biu`=1 and `sel`=10, sampled at posedge.
  - On a request, latch `op_sel`, `addr_a`, and `addr_b`, then go to WAIT.
  - `op_sel`=11: no state change, `err`=1 for one cycle, no bus drive, no memory access.
- **WAIT**
  - `ready_biu`=0.
  - A 4-bit counter counts WAIT_CYCLES edges, then moves to DONE.
  - If WAIT_CYCLES=0, WAIT lasts exactly one cycle.
- **Write (`op_sel`=10)**
  - `bus` is sampled on the WAIT→DONE edge into mem[latched `addr_a`].
- **DONE**
  - `ready_biu`=1.
  - For reads, `bus` is driven with mem[latched addr], where addr = `addr_a` for op 00 and `addr_b` for op 01.
  - The bus driver enable is combinational: state==DONE & `cs_biu` & (`op_sel`==latched op) & read. The bus is released in the same cycle the EU drops `cs_biu` or changes `op_sel`.
  - DONE→IDLE when `cs_biu`=0 or `op_sel` differs from the latched op. A changed `op_sel` with `cs_biu`=1 is treated as a new request on the following IDLE cycle.
- **Load port**
  - Honored only in IDLE with no request accepted the same edge. Otherwise the load is dropped silently.
  - Load and EU write are therefore never simultaneous.
- **Reset (any time, including mid-access)**
  - State returns to IDLE, `ready_biu`=1, `err`=0, bus released, counter=0.
  - All memory words are cleared to 0.

## Timing
- Request accepted at edge N.
- `ready_biu` is low from N through N+WAIT_CYCLES (minimum one cycle) and high from edge N+max(WAIT_CYCLES,1).
- Read data is valid on `bus` in the same cycle `ready_biu` rises, and held while the request persists.
- Write data must be stable on `bus` on the edge where `ready_biu` rises.
- Back-to-back accesses: one IDLE cycle minimum between accesses.
- `err` is registered: high exactly one cycle after the sampling edge.

## Configuration
- `BIU_WAIT_EN` defined: WAIT length = WAIT_CYCLES as above.
- `BIU_WAIT_EN` undefined: the counter is removed and WAIT is always exactly one cycle, independent of WAIT_CYCLES.

## Test plan
- **Reset and idle:** `rst_n`=0 → `ready_biu`=1, `err`=0, `bus`=Z. Load mem[3]=16'h1234 via `ld_en`; a read of A with `addr_a`=3 → `bus`=16'h1234.
- **Read B with default wait:** `cs_biu`=1, `sel`=10, `op_sel`=01, `addr_b`=5 (mem[5]=16'h00FF), WAIT_CYCLES=2 → `ready_biu` low 2 cycles, then high with `bus`=16'h00FF. Drop `cs_biu` → `bus`=Z the same cycle.
- **Write:** `op_sel`=10, `addr_a`=7, EU drives 16'hBEEF → mem[7]=16'hBEEF; a subsequent read A at `addr_a`=7 returns 16'hBEEF; `bus` is never driven by this block during the write.
- **Reserved op:** `op_sel`=11 → `err` pulses once, `ready_biu` stays 1, `bus`=Z, memory unchanged.
- **Reset mid-WAIT:** assert `rst_n`=0 during WAIT → `ready_biu`=1 immediately, all memory reads back 0, and the next request completes normally.
- **EU-style sequence:** read A (9), then read B (4) by changing only `op_sel` with `cs_biu` held → second access restarts WAIT and returns mem[4]. With `BIU_WAIT_EN` undefined → each access has exactly one low cycle.
